// File: rtl/iterative_divider_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg: shared types and the single restoring-division step used by
// iterative_divider (and by future multi-bit-per-cycle variants).
//
// Contents
//   DIV_MAX_W     widest operand the shared types/function can carry
//   div_state_e   divider FSM states
//   div_req_t     operand pair + signedness
//   div_resp_t    quotient, remainder, divide-by-zero flag
//   div_step_t    result of one restoring iteration
//   div_step()    one radix-2 restoring step
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int unsigned DIV_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIXUP,
        DONE
    } div_state_e;

    typedef struct packed {
        logic [DIV_MAX_W-1:0] a;
        logic [DIV_MAX_W-1:0] b;
        logic                 op_signed;
    } div_req_t;

    typedef struct packed {
        logic [DIV_MAX_W-1:0] quotient;
        logic [DIV_MAX_W-1:0] remainder;
        logic                 div_by_zero;
    } div_resp_t;

    typedef struct packed {
        logic [DIV_MAX_W:0] rem;
        logic               q_bit;
    } div_step_t;

    // Shift the next dividend bit into the partial remainder and subtract the
    // divisor when it fits. Callers zero-extend narrower operands; the
    // partial remainder entering a step is always below the divisor, so the
    // extra top bit of the shifted value is only there to keep the compare
    // from overflowing.
    function automatic div_step_t div_step(
        input logic [DIV_MAX_W:0]   rem,
        input logic                 a_bit,
        input logic [DIV_MAX_W-1:0] divisor
    );
        div_step_t            res;
        logic [DIV_MAX_W+1:0] shifted;
        logic [DIV_MAX_W+1:0] diff;
        shifted = {rem, a_bit};
        diff    = shifted - {2'b00, divisor};
        if (shifted >= {2'b00, divisor}) begin
            res.rem   = diff[DIV_MAX_W:0];
            res.q_bit = 1'b1;
        end else begin
            res.rem   = shifted[DIV_MAX_W:0];
            res.q_bit = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/iterative_divider_if.sv
// -----------------------------------------------------------------------------
// iterative_divider_if: request/response handshake bundle of the divider.
//
//   in_valid / in_ready         operand handshake (master -> divider)
//   input_a, input_b, op_signed dividend, divisor, signed select
//   out_valid / out_ready       result handshake (divider -> master)
//   output_quotient/remainder   results, div_by_zero flag
//
// modport master: the requesting/consuming side.
// modport slave : the divider.
// -----------------------------------------------------------------------------
interface iterative_divider_if #(
    parameter int WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic             op_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] output_quotient;
    logic [WIDTH-1:0] output_remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, input_a, input_b, op_signed, out_ready,
        input  in_ready, out_valid, output_quotient, output_remainder, div_by_zero
    );

    modport slave (
        input  in_valid, input_a, input_b, op_signed, out_ready,
        output in_ready, out_valid, output_quotient, output_remainder, div_by_zero
    );

endinterface

// File: rtl/iterative_divider.sv
// -----------------------------------------------------------------------------
// iterative_divider: multi-cycle radix-2 restoring divider (RISC-V
// DIV/DIVU/REM/REMU semantics), one quotient bit per cycle.
//
// Ports
//   clock  in   sole clock, rising edge
//   reset  in   synchronous active-high reset; clears state and outputs
//   flush  in   abort any operation; a same-cycle request is dropped
//   bus    slave modport of iterative_divider_if (operand/result handshake)
//
// Latency: accept in cycle 0, out_valid in cycle WIDTH+2 (cycle 1 on a zero
// divisor). Results are held until out_ready. WIDTH must be 2..DIV_MAX_W.
// -----------------------------------------------------------------------------
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    iterative_divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       r_state;
    div_state_e       w_state_next;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_work;     // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   r_rem;
    logic             r_q_neg;
    logic             r_r_neg;

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic             r_dbz;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic             w_cnt_last;

    logic [DIV_MAX_W:0]   w_rem_ext;
    logic [DIV_MAX_W-1:0] w_div_ext;
    div_step_t            w_step;

    assign w_accept   = bus.in_valid & (r_state == IDLE) & ~flush;
    assign w_a_neg    = bus.op_signed & bus.input_a[WIDTH-1];
    assign w_b_neg    = bus.op_signed & bus.input_b[WIDTH-1];
    // The most negative value negates to itself, which read unsigned is the
    // correct magnitude 2^(WIDTH-1).
    assign w_a_mag    = w_a_neg ? -bus.input_a : bus.input_a;
    assign w_b_mag    = w_b_neg ? -bus.input_b : bus.input_b;
    assign w_b_zero   = (bus.input_b == '0);
    assign w_cnt_last = (r_cnt == '0);

    always_comb begin
        w_rem_ext            = '0;
        w_rem_ext[WIDTH:0]   = r_rem;
        w_div_ext            = '0;
        w_div_ext[WIDTH-1:0] = r_divisor;
        w_step               = div_step(w_rem_ext, r_work[WIDTH-1], w_div_ext);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush overrides every other input
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (bus.in_valid) w_state_next = w_b_zero ? DONE : ITER;
                ITER:    if (w_cnt_last)   w_state_next = FIXUP;
                FIXUP:                     w_state_next = DONE;
                DONE:    if (bus.out_ready) w_state_next = IDLE;
                default:                   w_state_next = IDLE;
            endcase
        end
    end

    // Datapath. Result registers are written only on the transitions into
    // DONE (zero-divisor accept, FIXUP), so they stay stable while held.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_quot    <= '0;
            r_remd    <= '0;
            r_dbz     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_work    <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_rem     <= '0;
                        r_cnt     <= CW'(WIDTH - 1);
                        r_q_neg   <= w_a_neg ^ w_b_neg;
                        r_r_neg   <= w_a_neg;
                        if (w_b_zero) begin
                            r_quot <= '1;
                            r_remd <= bus.input_a;
                            r_dbz  <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    r_rem  <= w_step.rem[WIDTH:0];
                    r_work <= {r_work[WIDTH-2:0], w_step.q_bit};
                    r_cnt  <= r_cnt - CW'(1);
                end
                FIXUP: begin
                    if (!flush) begin
                        r_quot <= r_q_neg ? -r_work : r_work;
                        r_remd <= r_r_neg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                        r_dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready         = (r_state == IDLE);
    assign bus.out_valid        = (r_state == DONE);
    assign bus.output_quotient  = r_quot;
    assign bus.output_remainder = r_remd;
    assign bus.div_by_zero      = r_dbz;

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Parametrised multi-cycle radix-2 restoring divider for the execute stage's M-extension unit. Accepts one operand pair through a valid/ready handshake and supports signed and unsigned operation. Holds the quotient and remainder until the consumer accepts them. Divide-by-zero, signed overflow and pipeline flush behave as RISC-V DIV/DIVU/REM/REMU require.

## Interface
- `WIDTH`, default 32: operand and result width; any value ≥ 2.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  abort any operation in flight; same-cycle request is dropped.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `input_a`  in  WIDTH  dividend.
- `input_b`  in  WIDTH  divisor.
- `op_signed`  in  1  1 = two's-complement operands/results, 0 = unsigned.
- `out_valid`  out  1  results available.
- `out_ready`  in  1  consumer takes results.
- `output_quotient`  out  WIDTH  quotient.
- `output_remainder`  out  WIDTH  remainder; sign follows dividend.
- `div_by_zero`  out  1  result came from a zero divisor; qualified by `out_valid`.

## Operation
- States:
  - IDLE: `in_ready`=1. On accept (`in_valid & in_ready & ~flush`), capture `|a|`, `|b|` (magnitudes only when `op_signed`), the quotient sign `sa^sb` and the remainder sign `sa`.
    - If `b`==0, go to DONE.
    - Otherwise go to ITER with the counter at WIDTH-1.
  - ITER: one quotient bit per cycle, MSB first.
    - Step: `rem = {rem, a_bit}`; if `rem >= |b|`, subtract `|b|` and set the quotient bit.
    - Move to FIXUP when the counter reaches 0.
  - FIXUP: negate the quotient if its sign is set; negate the remainder if the dividend was negative. Go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- Width rules:
  - Partial remainder is WIDTH+1 bits so the compare never overflows.
  - Magnitude of the most negative value is the unsigned 2^(WIDTH-1), held in WIDTH bits.
  - Counter is `$clog2(WIDTH)` bits.
- Divide by zero: quotient = all ones, remainder = `input_a` unmodified, `div_by_zero`=1, for both signed and unsigned.
- Signed overflow (most-negative / -1) needs no special path. The normal datapath yields quotient = most-negative and remainder = 0, which is the required result.
- `flush` in any state: next state IDLE, `out_valid` low next cycle, no result delivered. `flush` has priority over `in_valid` and `out_ready`.
- `reset` mid-operation: same effect as `flush`, plus all outputs are cleared.
- Outputs are registered. They change only on entry to DONE and stay stable while `out_valid & ~out_ready`.
- Inputs are sampled only at accept. Changes to them afterwards have no effect.

## Timing
- Reset values: state IDLE, `in_ready`=1 in the cycle after reset deasserts, `out_valid`=0, `output_quotient`=0, `output_remainder`=0, `div_by_zero`=0.
- Cycle numbering: the accept cycle is cycle 0.
  - ITER occupies cycles 1..WIDTH.
  - FIXUP occupies cycle WIDTH+1.
  - `out_valid` rises in cycle WIDTH+2 (34 for WIDTH=32).
- Divide by zero: `out_valid` in cycle 1.
- Result handshake in cycle n: IDLE and `in_ready`=1 in cycle n+1. No same-cycle result/accept overlap, so throughput is one operation per WIDTH+3 cycles.
- `in_ready` is a pure function of state, with no combinational path from `in_valid` or `out_ready`.

## Structure
- Shared package `div_pkg`:
  - `div_state_e` enum (IDLE, ITER, FIXUP, DONE).
  - `div_req_t` struct: a, b, op_signed.
  - `div_resp_t` struct: quotient, remainder, div_by_zero.
  - Pure function `div_step` for one restoring iteration, reused by future multi-bit variants.
- Single module; no sub-module is warranted. Sign handling and the iteration live in one FSM with one datapath register set.

## Test plan
- Unsigned 100/7, WIDTH=32 → quotient 14, remainder 2; `out_valid` first high in cycle 34.
- Signed -7/2 (0xFFFFFFF9/0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Same bits with `op_signed`=0 → quotient 0x7FFFFFFC, remainder 1.
- Divide by zero, signed 5/0 → quotient 0xFFFFFFFF, remainder 5, `div_by_zero`=1, `out_valid` in cycle 1. Also signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0, `div_by_zero`=0.
- Backpressure: hold `out_ready` low 10 cycles after `out_valid` → outputs stable and `in_ready`=0 throughout; release → IDLE the next cycle, then back-to-back accept works.
- Flush at cycle 10 of ITER → `out_valid` never rises and `in_ready`=1 next cycle. A subsequent 9/3 yields 3 r 0 with no stale bits. Repeat with `reset` instead of `flush` → all outputs read 0.
- Random sweep at WIDTH=8 and 32, signed and unsigned, including 0, 1, -1 and min/max operands, against a reference model: all results and latencies match.
